// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared constants and state encoding for the shift arbiter
package shift_arbiter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/shift_arbiter_shift_core.sv
// rtl/shift_arbiter_shift_core.sv - combinational sll/sra datapath with op select
module shift_core #(
  parameter int WIDTH   = shift_arbiter_pkg::WIDTH,
  parameter int SHAMT_W = shift_arbiter_pkg::SHAMT_W
) (
  input  logic               op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   result
);

  import shift_arbiter_pkg::*;

  logic [WIDTH-1:0] sll_result;
  logic [WIDTH-1:0] sra_result;

  sll_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_sll (
    .data   (data),
    .shamt  (shamt),
    .result (sll_result)
  );

  sra_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_sra (
    .data   (data),
    .shamt  (shamt),
    .result (sra_result)
  );

  // Both cores run every cycle; the latched op picks which one is kept.
  always_comb begin
    result = sll_result;
    if (op == OP_SRA) result = sra_result;
  end

endmodule

// File: rtl/sll_core.sv
// rtl/sll_core.sv - logical-left shift core, zero fill
module sll_core #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result
);

  // Shift amount is already WIDTH-modulo by its width.
  assign result = data << shamt;

endmodule

// File: rtl/sra_core.sv
// rtl/sra_core.sv - arithmetic-right shift core, sign fill from the top bit
module sra_core #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result
);

  // Signed view makes >>> replicate bit WIDTH-1 into the vacated positions.
  assign result = $signed(data) >>> shamt;

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one shift datapath between two requesters
module shift_arbiter #(
  parameter int   WIDTH     = shift_arbiter_pkg::WIDTH,
  parameter int   SHAMT_W   = shift_arbiter_pkg::SHAMT_W,
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               op0,
  input  logic [SHAMT_W-1:0] shamt0,
  input  logic [WIDTH-1:0]   data0,
  input  logic               req1,
  input  logic               op1,
  input  logic [SHAMT_W-1:0] shamt1,
  input  logic [WIDTH-1:0]   data1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  import shift_arbiter_pkg::*;

  state_t             state;
  logic               prio;
  logic               op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [WIDTH-1:0]   data_q;
  logic               id_q;
  logic [WIDTH-1:0]   shift_out;

  // Grants only from IDLE; the priority pointer breaks ties so both never fire.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_IDLE) begin
      gnt0 = req0 & (~req1 | (prio == 1'b0));
      gnt1 = req1 & (~req0 | (prio == 1'b1));
    end
  end

  assign busy = (state == ST_EXEC);

  shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift_core (
    .op     (op_q),
    .shamt  (shamt_q),
    .data   (data_q),
    .result (shift_out)
  );

  // Arbiter FSM: capture winner's operands in IDLE, register the shift result in EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      prio    <= INIT_PRIO;
      op_q    <= 1'b0;
      shamt_q <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt0) begin
            op_q    <= op0;
            shamt_q <= shamt0;
            data_q  <= data0;
            id_q    <= 1'b0;
            prio    <= 1'b1;
            state   <= ST_EXEC;
          end else if (gnt1) begin
            op_q    <= op1;
            shamt_q <= shamt1;
            data_q  <= data1;
            id_q    <= 1'b1;
            prio    <= 1'b0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result <= shift_out;
          done0  <= ~id_q;
          done1  <= id_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a behavioural reference
module tb_shift_arbiter;

  localparam logic TB_INIT_PRIO = 1'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [4:0]  shamt0 = '0, shamt1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] result;

  shift_arbiter #(
    .WIDTH     (32),
    .SHAMT_W   (5),
    .INIT_PRIO (TB_INIT_PRIO)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .op0    (op0),
    .shamt0 (shamt0),
    .data0  (data0),
    .req1   (req1),
    .op1    (op1),
    .shamt1 (shamt1),
    .data1  (data1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          id;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_busy = 1'b0;
  bit          m_prio = TB_INIT_PRIO;
  logic [31:0] last_result = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference shift from arithmetic: multiply for left, floor division for right.
  function automatic logic [31:0] ref_shift(input bit op, input int sh, input logic [31:0] d);
    longint unsigned p;
    longint unsigned pw;
    pw = 64'd1 << sh;
    if (!op) begin
      p = {32'd0, d} * pw;
      return p[31:0];
    end
    if (!d[31]) return 32'(({32'd0, d}) / pw);
    return ~32'(({32'd0, ~d}) / pw);
  endfunction

  // Reference arbiter: one op per two cycles, round-robin among live requests.
  always @(negedge clock) begin
    bit   e0, e1;
    exp_t ne;
    if (!reset) begin
      e0 = !m_busy && req0 && (!req1 || !m_prio);
      e1 = !m_busy && req1 && (!req0 || m_prio);
      check("gnt0", 32'(gnt0), 32'(e0));
      check("gnt1", 32'(gnt1), 32'(e1));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (e0 || e1) begin
        ne.id  = e1;
        ne.res = e1 ? ref_shift(op1, int'(shamt1), data1) : ref_shift(op0, int'(shamt0), data0);
        ne.due = cyc + 2;
        exp_q.push_back(ne);
        m_busy = 1'b1;
        m_prio = e0;
      end
    end
  end

  // Monitor: pops the scoreboard on the cycle a completion is due.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("done0", 32'(done0), 32'(!e.id));
        check("done1", 32'(done1), 32'(e.id));
        check("result", result, e.res);
        last_result = e.res;
      end else begin
        check("done0_idle", 32'(done0), 32'd0);
        check("done1_idle", 32'(done1), 32'd0);
        check("result_hold", result, last_result);
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_prio = TB_INIT_PRIO;
    last_result = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input bit id, input bit r, input bit op, input logic [4:0] sh, input logic [31:0] d);
    if (id) begin
      req1 = r; op1 = op; shamt1 = sh; data1 = d;
    end else begin
      req0 = r; op0 = op; shamt0 = sh; data0 = d;
    end
  endtask

  // Raise a request, wait (bounded) for its grant, drop it just after the grant edge.
  task automatic do_op(input bit id, input bit op, input logic [4:0] sh, input logic [31:0] d);
    bit got;
    got = 1'b0;
    drive(id, 1'b1, op, sh, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (id ? gnt1 : gnt0) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL grant_timeout: requester %0d got no grant, expected one within 20 cycles", id);
    end
    @(posedge clock);
    #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic run_directed(input string name, input bit id, input bit op, input logic [4:0] sh,
                              input logic [31:0] d, input logic [31:0] exp);
    do_op(id, op, sh, d);
    @(negedge clock);
    @(negedge clock);
    check({name, "_result"}, result, exp);
    check({name, "_done"}, {30'd0, done1, done0}, id ? 32'd2 : 32'd1);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_shamt();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd31;
      default: return 5'($urandom);
    endcase
  endfunction

  // Random requester: holds until granted, sometimes abandons, sometimes chains ops.
  task automatic requester(input bit id, input int nops);
    bit cur_req, granted, abandoned;
    cur_req = 1'b0;
    for (int n = 0; n < nops; n++) begin
      if (!cur_req) begin
        repeat ($urandom_range(3)) begin
          @(posedge clock);
          #1;
        end
        drive(id, 1'b1, 1'($urandom), rand_shamt(), rand_data());
      end
      granted = 1'b0;
      abandoned = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clock);
        if (id ? gnt1 : gnt0) begin
          granted = 1'b1;
          break;
        end
        @(posedge clock);
        #1;
        if ($urandom_range(15) == 0) begin
          abandoned = 1'b1;
          break;
        end
      end
      if (!granted && !abandoned) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_grant_timeout: requester %0d starved, expected grant within 30 cycles", id);
      end
      if (granted) begin
        @(posedge clock);
        #1;
      end
      if (granted && $urandom_range(1) == 1) begin
        drive(id, 1'b1, 1'($urandom), rand_shamt(), rand_data());
        cur_req = 1'b1;
      end else begin
        drive(id, 1'b0, 1'b0, 5'd0, 32'd0);
        cur_req = 1'b0;
      end
    end
    drive(id, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit winner;
    bit got;
    apply_reset();
    @(negedge clock);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    @(posedge clock);
    #1;

    run_directed("t1_sra", 1'b0, 1'b1, 5'd4, 32'h8000_0000, 32'hF800_0000);
    run_directed("t2_sll31", 1'b1, 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000);
    run_directed("t2_pass", 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_directed("t4_sra_pos", 1'b0, 1'b1, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000);
    run_directed("t4_sra_neg", 1'b1, 1'b1, 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 5'd1, 32'h0000_0003);
    drive(1'b1, 1'b1, 1'b1, 5'd2, 32'hF000_0000);
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (gnt0 || gnt1) begin
          got = 1'b1;
          break;
        end
      end
      winner = gnt1;
      n_checks++;
      if (!got) begin
        n_errors++;
        $display("FAIL fair_timeout: no grant in round %0d, expected one within 10 cycles", i);
      end
      check("fair_order", 32'(winner), 32'(i % 2));
    end
    @(posedge clock);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    do_op(1'b1, 1'b1, 5'd3, 32'h8000_0000);
    reset = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_prio = TB_INIT_PRIO;
    last_result = '0;
    #1;
    check("t5_result", result, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", {30'd0, done1, done0}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    run_directed("t5_after", 1'b1, 1'b0, 5'd4, 32'h0000_00F1, 32'h0000_0F10);

    do_op(1'b0, 1'b0, 5'd8, 32'h0000_00AB);
    data0 = 32'hFFFF_FFFF;
    shamt0 = 5'd1;
    @(negedge clock);
    @(negedge clock);
    check("t6_result", result, 32'h0000_AB00);
    repeat (10) @(negedge clock);
    check("t6_hold", result, 32'h0000_AB00);
    @(posedge clock);
    #1;
    data0 = 32'd0;
    shamt0 = 5'd0;

    fork
      requester(1'b0, 40);
      requester(1'b1, 40);
    join
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
